// File: rtl/div_pkg.sv
// Shared encodings and helpers for the multi-cycle restoring divider.
package div_pkg;

  localparam int unsigned DIV_W  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WORK_W = 2 * DIV_W + 1;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement negate; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [DIV_W-1:0] neg(input logic [DIV_W-1:0] x);
    return ~x + DIV_W'(1);
  endfunction

endpackage

// File: rtl/div.sv
// Signed/unsigned 32-bit restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}, held while start_i stays high.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORK_W-1:0]      work_q, work_d;
  logic [DATA_W-1:0]      divisor_q, divisor_d;
  logic                   s1_q, s1_d, s2_q, s2_d, sgn_q, sgn_d;
  logic [2*DATA_W-1:0]    result_q, result_d;
  logic                   ready_q, ready_d;

  logic [DATA_W:0]        trial_c;
  logic [WORK_W-1:0]      step_c;
  logic [DATA_W-1:0]      quot_c, rem_c, mag1_c, mag2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      sgn_q     <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sgn_q     <= sgn_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sgn_d     = sgn_q;
    result_d  = result_q;
    ready_d   = ready_q;

    mag1_c = (signed_div_i && opdata1_i[DATA_W-1]) ? neg(opdata1_i) : opdata1_i;
    mag2_c = (signed_div_i && opdata2_i[DATA_W-1]) ? neg(opdata2_i) : opdata2_i;

    // Restoring step: keep the difference only when it did not borrow.
    trial_c = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    step_c  = trial_c[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                              : {trial_c[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
    quot_c  = step_c[DATA_W-1:0];
    rem_c   = step_c[2*DATA_W:DATA_W+1];
    if (sgn_q && (s1_q ^ s2_q)) quot_c = neg(quot_c);
    if (sgn_q && s1_q)          rem_c  = neg(rem_c);

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            work_d    = {DATA_W'(0), mag1_c, 1'b0};
            divisor_d = mag2_c;
            s1_d      = opdata1_i[DATA_W-1];
            s2_d      = opdata2_i[DATA_W-1];
            sgn_d     = signed_div_i;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          state_d = DivEnd;
          work_d  = '0;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          cnt_d    = '0;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
          // Last iteration folds in the sign correction.
          state_d = DivEnd;
          cnt_d   = '0;
          work_d  = {rem_c, 1'b0, quot_c};
        end else begin
          work_d = step_c;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (start_i == DivStart) begin
          ready_d  = DivResultReady;
          result_d = {work_q[2*DATA_W:DATA_W+1], work_q[DATA_W-1:0]};
        end else begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
